// File: rtl/mcpu_ctrl.sv
// mcpu_ctrl: multi-cycle MIPS main controller, a Moore FSM sequencing one datapath step per state
module mcpu_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Inst,
  input  logic        zero,
  input  logic        overflow,
  input  logic        MIO_ready,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  MemtoReg,
  output logic [1:0]  RegDst,
  output logic [1:0]  Dout_ctrl,
  output logic [1:0]  Din_ctrl,
  output logic [1:0]  cp0_wr,
  output logic [1:0]  cp0_wd,
  output logic [3:0]  ALU_operation,
  output logic [2:0]  PCSource,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        Branch,
  output logic        IorD,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        cp0_wt,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [4:0]  state
);
  localparam logic [4:0] S_IF = 5'd0, S_ID = 5'd1, S_REX = 5'd2, S_RWB = 5'd3, S_IEX = 5'd4,
    S_IWB = 5'd5, S_MA = 5'd6, S_MRD = 5'd7, S_LWB = 5'd8, S_MWR = 5'd9, S_BR = 5'd10,
    S_J = 5'd11, S_JAL = 5'd12, S_JR = 5'd13, S_LUI = 5'd14, S_MFC0 = 5'd15, S_MTC0 = 5'd16,
    S_ERET = 5'd17, S_EXC = 5'd18;
  localparam logic [3:0] ALU_AND = 4'd0, ALU_OR = 4'd1, ALU_ADD = 4'd2, ALU_XOR = 4'd3,
    ALU_NOR = 4'd4, ALU_SRL = 4'd5, ALU_SUB = 4'd6, ALU_SLT = 4'd7, ALU_SLL = 4'd8;
  logic [5:0] op, fn;
  logic [4:0] rs, nxt;
  logic [3:0] r_op, i_op;
  logic [1:0] din_sel, dout_sel;
  logic       r_ok, ovf, unused_ok;
  assign op = Inst[31:26];
  assign rs = Inst[25:21];
  assign fn = Inst[5:0];
  assign unused_ok = ^{zero, Inst[20:6]};
  assign r_ok = fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h00, 6'h02};
  // unknown funct keeps ADD; the result is discarded because the FSM goes to EXC
  assign r_op = (fn == 6'h20 || fn == 6'h21) ? ALU_ADD :
                (fn == 6'h22 || fn == 6'h23) ? ALU_SUB :
                fn == 6'h24 ? ALU_AND : fn == 6'h25 ? ALU_OR : fn == 6'h26 ? ALU_XOR :
                fn == 6'h27 ? ALU_NOR : fn == 6'h2a ? ALU_SLT : fn == 6'h00 ? ALU_SLL :
                fn == 6'h02 ? ALU_SRL : ALU_ADD;
  assign i_op = op == 6'h0c ? ALU_AND : op == 6'h0d ? ALU_OR : op == 6'h0e ? ALU_XOR :
                op == 6'h0a ? ALU_SLT : ALU_ADD;
  assign din_sel  = op == 6'h25 ? 2'd1 : op == 6'h24 ? 2'd2 : 2'd0;
  assign dout_sel = op == 6'h29 ? 2'd1 : op == 6'h28 ? 2'd2 : 2'd0;
  // state register plus the overflow flag latched in the execute steps
  always_ff @(posedge clk)
    if (reset) begin
      state <= S_IF;
      ovf   <= 1'b0;
    end else begin
      state <= nxt;
      ovf   <= state == S_REX ? overflow & (fn == 6'h20 || fn == 6'h22) :
               state == S_IEX ? overflow & (op == 6'h08) :
               state == S_IF  ? 1'b0 : ovf;
    end
  // next-state logic including the opcode dispatch in ID
  always_comb begin
    nxt = S_IF;
    case (state)
      S_IF:         nxt = MIO_ready ? S_ID : S_IF;
      S_ID:
        case (op)
          6'h00:                                     nxt = fn == 6'h08 ? S_JR : S_REX;
          6'h23, 6'h25, 6'h24, 6'h2b, 6'h29, 6'h28:  nxt = S_MA;
          6'h04, 6'h05:                              nxt = S_BR;
          6'h02:                                     nxt = S_J;
          6'h03:                                     nxt = S_JAL;
          6'h08, 6'h0c, 6'h0d, 6'h0e, 6'h0a:         nxt = S_IEX;
          6'h0f:                                     nxt = S_LUI;
          6'h10: nxt = rs == 5'h00 ? S_MFC0 : rs == 5'h04 ? S_MTC0 :
                       (rs == 5'h10 && fn == 6'h18) ? S_ERET : S_EXC;
          default:                                   nxt = S_EXC;
        endcase
      S_REX:        nxt = r_ok ? S_RWB : S_EXC;
      S_RWB, S_IWB: nxt = ovf ? S_EXC : S_IF;
      S_IEX:        nxt = S_IWB;
      S_MA:         nxt = op[3] ? S_MWR : S_MRD;
      S_MRD:        nxt = MIO_ready ? S_LWB : S_MRD;
      S_MWR:        nxt = MIO_ready ? S_IF : S_MWR;
      default:      nxt = S_IF;
    endcase
  end
  // Moore output decode; IRWrite is the single Mealy term and reset masks every write or strobe
  always_comb begin
    {ALUSrcA, ALUSrcB, MemtoReg, RegDst, Dout_ctrl, Din_ctrl, cp0_wr, cp0_wd} = '0;
    ALU_operation = ALU_AND;
    PCSource = 3'd0;
    {PCWrite, PCWriteCond, Branch, IorD, IRWrite, RegWrite, cp0_wt, MemRead, MemWrite} = '0;
    case (state)
      S_IF:   begin MemRead = 1'b1; ALUSrcB = 2'd1; ALU_operation = ALU_ADD; PCWrite = 1'b1; IRWrite = MIO_ready; end
      S_ID:   begin ALUSrcB = 2'd3; ALU_operation = ALU_ADD; end
      S_REX:  begin ALUSrcA = (fn == 6'h00 || fn == 6'h02) ? 2'd2 : 2'd1; ALU_operation = r_op; end
      S_RWB:  begin RegDst = 2'd1; RegWrite = ~ovf; end
      S_IEX:  begin ALUSrcA = 2'd1; ALUSrcB = 2'd2; ALU_operation = i_op; end
      S_IWB:  RegWrite = ~ovf;
      S_MA:   begin ALUSrcA = 2'd1; ALUSrcB = 2'd2; ALU_operation = ALU_ADD; end
      S_MRD:  begin IorD = 1'b1; MemRead = 1'b1; end
      S_LWB:  begin MemtoReg = 2'd1; RegWrite = 1'b1; Din_ctrl = din_sel; end
      S_MWR:  begin IorD = 1'b1; MemWrite = 1'b1; Dout_ctrl = dout_sel; end
      S_BR:   begin ALUSrcA = 2'd1; ALU_operation = ALU_SUB; PCWriteCond = 1'b1; PCSource = 3'd1; Branch = op == 6'h04; end
      S_J:    begin PCWrite = 1'b1; PCSource = 3'd2; end
      S_JAL:  begin PCWrite = 1'b1; PCSource = 3'd2; RegDst = 2'd2; MemtoReg = 2'd3; RegWrite = 1'b1; end
      S_JR:   begin PCWrite = 1'b1; PCSource = 3'd3; end
      S_LUI:  begin MemtoReg = 2'd2; RegWrite = 1'b1; end
      S_MFC0: begin MemtoReg = 2'd1; Din_ctrl = 2'd3; RegWrite = 1'b1; end
      S_MTC0: cp0_wt = 1'b1;
      S_ERET: begin PCWrite = 1'b1; PCSource = 3'd4; end
      S_EXC:  begin cp0_wt = 1'b1; cp0_wr = 2'd1; cp0_wd = 2'd1; PCWrite = 1'b1; PCSource = 3'd5; end
      default: ;
    endcase
    if (reset) {PCWrite, PCWriteCond, IRWrite, RegWrite, cp0_wt, MemRead, MemWrite} = '0;
  end
endmodule

// File: tb/tb_mcpu_ctrl.sv
// tb_mcpu_ctrl: randomized instruction stream checked every cycle against a per-instruction step plan
module tb_mcpu_ctrl;
  localparam int S_IF = 0, S_ID = 1, S_REX = 2, S_RWB = 3, S_IEX = 4, S_IWB = 5, S_MA = 6,
    S_MRD = 7, S_LWB = 8, S_MWR = 9, S_BR = 10, S_J = 11, S_JAL = 12, S_JR = 13, S_LUI = 14,
    S_MFC0 = 15, S_MTC0 = 16, S_ERET = 17, S_EXC = 18;
  typedef struct packed {
    logic [1:0] a, b, m, d, dout, din, wr, wd;
    logic [3:0] op;
    logic [2:0] pcs;
    logic pw, pwc, br, iord, irw, rw, wt, mr, mw;
    logic [4:0] st;
  } out_t;
  logic clk = 1'b0, reset = 1'b1, zero = 1'b0, overflow = 1'b0, MIO_ready = 1'b1;
  logic [31:0] Inst = 32'h0;
  logic [1:0] ALUSrcA, ALUSrcB, MemtoReg, RegDst, Dout_ctrl, Din_ctrl, cp0_wr, cp0_wd;
  logic [3:0] ALU_operation;
  logic [2:0] PCSource;
  logic PCWrite, PCWriteCond, Branch, IorD, IRWrite, RegWrite, cp0_wt, MemRead, MemWrite;
  logic [4:0] state;
  out_t got, exp_o = '0;
  out_t tr[$];
  logic chk_en = 1'b0;
  int compared = 0, mismatched = 0;
  always #5 clk = ~clk;
  mcpu_ctrl dut (
    .clk(clk), .reset(reset), .Inst(Inst), .zero(zero), .overflow(overflow), .MIO_ready(MIO_ready),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .Dout_ctrl(Dout_ctrl), .Din_ctrl(Din_ctrl), .cp0_wr(cp0_wr), .cp0_wd(cp0_wd),
    .ALU_operation(ALU_operation), .PCSource(PCSource), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .Branch(Branch), .IorD(IorD), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .cp0_wt(cp0_wt), .MemRead(MemRead), .MemWrite(MemWrite), .state(state)
  );
  assign got = {ALUSrcA, ALUSrcB, MemtoReg, RegDst, Dout_ctrl, Din_ctrl, cp0_wr, cp0_wd,
                ALU_operation, PCSource, PCWrite, PCWriteCond, Branch, IorD, IRWrite,
                RegWrite, cp0_wt, MemRead, MemWrite, state};
  function automatic logic [3:0] r_alu(input logic [5:0] f);
    case (f)
      6'h20, 6'h21: return 4'b0010;
      6'h22, 6'h23: return 4'b0110;
      6'h24: return 4'b0000;
      6'h25: return 4'b0001;
      6'h26: return 4'b0011;
      6'h27: return 4'b0100;
      6'h2a: return 4'b0111;
      6'h00: return 4'b1000;
      6'h02: return 4'b0101;
      default: return 4'b0010;
    endcase
  endfunction
  function automatic logic r_legal(input logic [5:0] f);
    return f inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h00, 6'h02};
  endfunction
  function automatic int first_step(input logic [31:0] i);
    logic [5:0] o, f;
    logic [4:0] rs;
    o = i[31:26]; f = i[5:0]; rs = i[25:21];
    if (o == 6'h00) return f == 6'h08 ? S_JR : S_REX;
    if (o inside {6'h23, 6'h25, 6'h24, 6'h2b, 6'h29, 6'h28}) return S_MA;
    if (o inside {6'h04, 6'h05}) return S_BR;
    if (o == 6'h02) return S_J;
    if (o == 6'h03) return S_JAL;
    if (o inside {6'h08, 6'h0c, 6'h0d, 6'h0e, 6'h0a}) return S_IEX;
    if (o == 6'h0f) return S_LUI;
    if (o == 6'h10) begin
      if (rs == 5'h00) return S_MFC0;
      if (rs == 5'h04) return S_MTC0;
      if (rs == 5'h10 && f == 6'h18) return S_ERET;
    end
    return S_EXC;
  endfunction
  function automatic out_t model(input int s, input logic [31:0] i, input logic r, input logic rdy, input logic ov);
    out_t o;
    logic [5:0] opc, f;
    o = '0; opc = i[31:26]; f = i[5:0]; o.st = 5'(s);
    case (s)
      S_IF:   begin o.mr = 1'b1; o.b = 2'd1; o.op = 4'b0010; o.pw = 1'b1; o.irw = rdy; end
      S_ID:   begin o.b = 2'd3; o.op = 4'b0010; end
      S_REX:  begin o.a = (f == 6'h00 || f == 6'h02) ? 2'd2 : 2'd1; o.op = r_alu(f); end
      S_RWB:  begin o.d = 2'd1; o.rw = ~ov; end
      S_IEX:  begin
        o.a = 2'd1; o.b = 2'd2;
        o.op = opc == 6'h0c ? 4'b0000 : opc == 6'h0d ? 4'b0001 : opc == 6'h0e ? 4'b0011 :
               opc == 6'h0a ? 4'b0111 : 4'b0010;
      end
      S_IWB:  o.rw = ~ov;
      S_MA:   begin o.a = 2'd1; o.b = 2'd2; o.op = 4'b0010; end
      S_MRD:  begin o.iord = 1'b1; o.mr = 1'b1; end
      S_LWB:  begin o.m = 2'd1; o.rw = 1'b1; o.din = opc == 6'h25 ? 2'd1 : opc == 6'h24 ? 2'd2 : 2'd0; end
      S_MWR:  begin o.iord = 1'b1; o.mw = 1'b1; o.dout = opc == 6'h29 ? 2'd1 : opc == 6'h28 ? 2'd2 : 2'd0; end
      S_BR:   begin o.a = 2'd1; o.op = 4'b0110; o.pwc = 1'b1; o.pcs = 3'd1; o.br = opc == 6'h04; end
      S_J:    begin o.pw = 1'b1; o.pcs = 3'd2; end
      S_JAL:  begin o.pw = 1'b1; o.pcs = 3'd2; o.d = 2'd2; o.m = 2'd3; o.rw = 1'b1; end
      S_JR:   begin o.pw = 1'b1; o.pcs = 3'd3; end
      S_LUI:  begin o.m = 2'd2; o.rw = 1'b1; end
      S_MFC0: begin o.m = 2'd1; o.din = 2'd3; o.rw = 1'b1; end
      S_MTC0: o.wt = 1'b1;
      S_ERET: begin o.pw = 1'b1; o.pcs = 3'd4; end
      S_EXC:  begin o.wt = 1'b1; o.wr = 2'd1; o.wd = 2'd1; o.pw = 1'b1; o.pcs = 3'd5; end
      default: ;
    endcase
    if (r) {o.pw, o.pwc, o.irw, o.rw, o.wt, o.mr, o.mw} = '0;
    return o;
  endfunction
  always @(negedge clk)
    if (chk_en) begin
      compared++;
      if (got !== exp_o) begin
        mismatched++;
        $display("FAIL cycle_outputs t=%0t state got %0d required %0d, vector got %h required %h",
                 $time, got.st, exp_o.st, got, exp_o);
      end
    end
  task automatic pin(input string name, input logic [31:0] g, input logic [31:0] w);
    compared++;
    if (g !== w) begin
      mismatched++;
      $display("FAIL %s got %0h required %0h", name, g, w);
    end
  endtask
  // plan the step sequence of one instruction from the decode rules, then drive and track it
  task automatic run(input logic [31:0] inst, input int sif, input int sm, input logic ovin,
                     input logic zv, input int abort_at);
    int q[$];
    int f, w, s;
    logic ov;
    tr.delete();
    ov = 1'b0;
    for (int k = 0; k < sif; k++) q.push_back(S_IF | 64);
    q.push_back(S_IF);
    q.push_back(S_ID);
    f = first_step(inst);
    case (f)
      S_REX: begin
        q.push_back(S_REX);
        if (r_legal(inst[5:0])) begin
          ov = ovin & (inst[5:0] == 6'h20 || inst[5:0] == 6'h22);
          q.push_back(S_RWB);
          if (ov) q.push_back(S_EXC);
        end else q.push_back(S_EXC);
      end
      S_IEX: begin
        ov = ovin & (inst[31:26] == 6'h08);
        q.push_back(S_IEX);
        q.push_back(S_IWB);
        if (ov) q.push_back(S_EXC);
      end
      S_MA: begin
        w = inst[31:26] inside {6'h2b, 6'h29, 6'h28} ? S_MWR : S_MRD;
        q.push_back(S_MA);
        for (int k = 0; k < sm; k++) q.push_back(w | 64);
        q.push_back(w);
        if (w == S_MRD) q.push_back(S_LWB);
      end
      default: q.push_back(f);
    endcase
    foreach (q[k]) begin
      s = q[k] & 31;
      MIO_ready = (q[k] & 64) != 0 ? 1'b0 : (s == S_IF || s == S_MRD || s == S_MWR) ? 1'b1 : 1'($urandom);
      Inst = inst;
      zero = zv;
      overflow = (s == S_REX || s == S_IEX) ? ovin : 1'($urandom);
      reset = k == abort_at;
      exp_o = model(s, inst, reset, MIO_ready, ov);
      #1 tr.push_back(got);
      @(posedge clk);
      #1;
      if (reset) begin
        reset = 1'b0;
        break;
      end
    end
  endtask
  function automatic logic [31:0] rnd_inst();
    logic [5:0] fns [13] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h00, 6'h02, 6'h08, 6'h3f};
    logic [5:0] ops [18] = '{6'h23, 6'h25, 6'h24, 6'h2b, 6'h29, 6'h28, 6'h04, 6'h05, 6'h02,
                             6'h03, 6'h08, 6'h0c, 6'h0d, 6'h0e, 6'h0a, 6'h0f, 6'h10, 6'h10};
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0, 1: begin
        r[31:26] = 6'h00;
        if ($urandom_range(0, 3) != 0) r[5:0] = fns[4'($urandom_range(0, 12))];
      end
      2, 3, 4: r[31:26] = ops[5'($urandom_range(0, 17))];
      default: ;
    endcase
    if (r[31:26] == 6'h10)
      case ($urandom_range(0, 3))
        0: r[25:21] = 5'h00;
        1: r[25:21] = 5'h04;
        2: begin r[25:21] = 5'h10; r[5:0] = 6'h18; end
        default: ;
      endcase
    return r;
  endfunction
  initial begin
    int n;
    @(posedge clk);
    #1;
    exp_o = model(S_IF, 32'h0, 1'b1, 1'b1, 1'b0);
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    pin("reset_state", 32'(state), 32'(S_IF));
    pin("reset_strobes", 32'({PCWrite, PCWriteCond, IRWrite, RegWrite, cp0_wt, MemRead, MemWrite}), 32'h0);
    reset = 1'b0;
    run(32'h00221820, 0, 0, 1'b0, 1'b0, -1);
    pin("add_len", 32'(tr.size()), 32'd4);
    pin("add_seq", 32'({tr[0].st, tr[1].st, tr[2].st, tr[3].st}), 32'({5'd0, 5'd1, 5'd2, 5'd3}));
    pin("add_aluop", 32'(tr[2].op), 32'(4'b0010));
    pin("add_wb", 32'({tr[3].d, tr[3].rw}), 32'({2'd1, 1'b1}));
    run(32'h8C220004, 0, 3, 1'b0, 1'b0, -1);
    n = 0;
    foreach (tr[k]) if (tr[k].mr && tr[k].iord) n++;
    pin("lw_wait_cycles", 32'(n), 32'd4);
    pin("lw_len", 32'(tr.size()), 32'd8);
    pin("lw_lwb", 32'({tr[7].st, tr[7].m, tr[7].din}), 32'({5'd8, 2'd1, 2'd0}));
    run(32'h10220003, 0, 0, 1'b0, 1'b1, -1);
    pin("beq_len", 32'(tr.size()), 32'd3);
    pin("beq_br", 32'({tr[2].pwc, tr[2].br, tr[2].pcs}), 32'({1'b1, 1'b1, 3'd1}));
    run(32'h14220003, 0, 0, 1'b0, 1'b0, -1);
    pin("bne_len", 32'(tr.size()), 32'd3);
    pin("bne_branch", 32'({tr[2].pwc, tr[2].br}), 32'({1'b1, 1'b0}));
    run(32'h0C000010, 0, 0, 1'b0, 1'b0, -1);
    pin("jal_out", 32'({tr[2].pcs, tr[2].d, tr[2].m, tr[2].rw}), 32'({3'd2, 2'd2, 2'd3, 1'b1}));
    run(32'h00221820, 0, 0, 1'b1, 1'b0, -1);
    pin("ovf_len", 32'(tr.size()), 32'd5);
    pin("ovf_wb", 32'(tr[3].rw), 32'd0);
    pin("ovf_exc", 32'({tr[4].st, tr[4].wt, tr[4].wr, tr[4].wd, tr[4].pcs}),
        32'({5'd18, 1'b1, 2'd1, 2'd1, 3'd5}));
    run(32'hFC000000, 0, 0, 1'b0, 1'b0, -1);
    pin("illegal_exc", 32'({tr.size() == 3, tr[2].st}), 32'({1'b1, 5'd18}));
    run(32'h42000018, 0, 0, 1'b0, 1'b0, -1);
    pin("eret_out", 32'({tr[2].pcs, tr[2].pw}), 32'({3'd4, 1'b1}));
    repeat (400)
      run(rnd_inst(), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
          $urandom_range(0, 9) == 0 ? int'($urandom_range(0, 4)) : -1);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
